// File: rtl/ram2_sync_resp.sv
// 32x32 register-file responder: two registered kernel read ports, one kernel write port,
// debug write/read port, write-first forwarding, saturating write counter. Optional RAM_CLEAR_EN adds a post-reset clear sweep.
module ram2_sync_resp #(
   parameter int WIDTH = 32,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             rst,
   output logic             ready,
   input  logic [AW-1:0]    raddr0,
   input  logic [AW-1:0]    raddr1,
   output logic [WIDTH-1:0] rdata0,
   output logic [WIDTH-1:0] rdata1,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             wen,
   input  logic [AW-1:0]    debug_write_addr,
   input  logic [WIDTH-1:0] debug_write_data,
   input  logic             debug_write_en,
   input  logic [AW-1:0]    debug_addr,
   output logic [WIDTH-1:0] debug_data,
   output logic [15:0]      write_count
);

   localparam int DEPTH = 1 << AW;

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata0_q, rdata0_d;
   logic [WIDTH-1:0] rdata1_q, rdata1_d;
   logic [15:0]      count_q, count_d;
   logic             kern_we;

   // Kernel ports are only serviced in RUN and never while reset is held.
   assign ready   = (state_q == S_RUN) && !rst;
   assign kern_we = ready && wen;

`ifdef RAM_CLEAR_EN
   logic [AW-1:0]    ptr_q;
   logic [DEPTH-1:0] written_q;
   logic             sweep_we;

   assign sweep_we = (state_q == S_CLEAR) && !rst && !written_q[ptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_CLEAR;
         ptr_q     <= '0;
         written_q <= '0;
         if (debug_write_en) written_q[debug_write_addr] <= 1'b1;
      end else if (state_q == S_CLEAR) begin
         if (debug_write_en) written_q[debug_write_addr] <= 1'b1;
         ptr_q <= ptr_q + 1'b1;
         if (ptr_q == AW'(DEPTH - 1)) state_q <= S_RUN;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_RUN;
   end
`endif

   // Later assignments win: sweep < debug < kernel on the same address.
   always_ff @(posedge clk) begin
`ifdef RAM_CLEAR_EN
      if (sweep_we) mem_q[ptr_q] <= '0;
`endif
      if (debug_write_en) mem_q[debug_write_addr] <= debug_write_data;
      if (kern_we) mem_q[waddr] <= wdata;
   end

   always_comb begin
      rdata0_d = '0;
      rdata1_d = '0;
      if (ready) begin
         if (kern_we && raddr0 == waddr)                       rdata0_d = wdata;
         else if (debug_write_en && raddr0 == debug_write_addr) rdata0_d = debug_write_data;
         else                                                   rdata0_d = mem_q[raddr0];
         if (kern_we && raddr1 == waddr)                       rdata1_d = wdata;
         else if (debug_write_en && raddr1 == debug_write_addr) rdata1_d = debug_write_data;
         else                                                   rdata1_d = mem_q[raddr1];
      end
   end

   always_comb begin
      count_d = count_q;
      if (kern_we && count_q != 16'hFFFF) count_d = count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
         count_q  <= '0;
      end else begin
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         count_q  <= count_d;
      end
   end

   assign rdata0      = rdata0_q;
   assign rdata1      = rdata1_q;
   assign write_count = count_q;
   assign debug_data  = mem_q[debug_addr];

endmodule

// File: tb/tb_ram2_sync_resp.sv
// Directed bench for ram2_sync_resp: reset/preload, forwarding, collisions, mid-run reset, counter saturation.
module tb_ram2_sync_resp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ready;
   logic [4:0]  raddr0 = '0, raddr1 = '0, waddr = '0;
   logic [31:0] rdata0, rdata1, wdata = '0;
   logic        wen = 1'b0;
   logic [4:0]  debug_write_addr = '0, debug_addr = '0;
   logic [31:0] debug_write_data = '0, debug_data;
   logic        debug_write_en = 1'b0;
   logic [15:0] write_count;

   int checks = 0;
   int errors = 0;

   ram2_sync_resp dut (
      .clk(clk), .rst(rst), .ready(ready),
      .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0), .rdata1(rdata1),
      .waddr(waddr), .wdata(wdata), .wen(wen),
      .debug_write_addr(debug_write_addr), .debug_write_data(debug_write_data),
      .debug_write_en(debug_write_en), .debug_addr(debug_addr), .debug_data(debug_data),
      .write_count(write_count)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wen = 1'b0;
      debug_write_en = 1'b0;
   endtask

   task automatic peek(input logic [4:0] a, input logic [31:0] exp, input string name);
      debug_addr = a;
      #1;
      checks++;
      if (debug_data !== exp) begin
         errors++;
         $display("FAIL %s: debug_data@%0d got %h expected %h", name, a, debug_data, exp);
      end
   endtask

   // After reset release, wait for ready and verify the wait length.
   task automatic wait_ready_after_release();
      int cnt;
      int exp_cnt;
`ifdef RAM_CLEAR_EN
      exp_cnt = 32;
`else
      exp_cnt = 0;
`endif
      cnt = 0;
      #1;
      while (ready !== 1'b1 && cnt < 200) begin
         step();
         cnt++;
      end
      checks++;
      if (cnt != exp_cnt) begin
         errors++;
         $display("FAIL ready_delay: got %0d cycles expected %0d", cnt, exp_cnt);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      debug_write_en = 1'b1; debug_write_addr = 5'd4; debug_write_data = 32'd44;
      step();
      debug_write_addr = 5'd10; debug_write_data = 32'd10;
      wen = 1'b1; waddr = 5'd4; wdata = 32'd55; raddr0 = 5'd4; raddr1 = 5'd10;
      step();
      idle_inputs();
      checks++;
      if (rdata0 !== 32'd0 || rdata1 !== 32'd0) begin
         errors++;
         $display("FAIL reset_rdata: got %h/%h expected 0/0", rdata0, rdata1);
      end
      checks++;
      if (write_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d expected 0", write_count);
      end
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 0", ready);
      end
      rst = 1'b0;
`ifdef RAM_CLEAR_EN
      // Kernel write during CLEAR must be dropped.
      wen = 1'b1; waddr = 5'd10; wdata = 32'd77; raddr0 = 5'd10;
      step();
      checks++;
      if (rdata0 !== 32'd0 || write_count !== 16'd0) begin
         errors++;
         $display("FAIL clear_drop: rdata0 %h count %0d expected 0/0", rdata0, write_count);
      end
      wen = 1'b0;
      wait_ready_after_release_minus1();
      peek(5'd0, 32'd0, "clear_addr0");
`else
      wait_ready_after_release();
`endif
      peek(5'd10, 32'd10, "preload10");
      peek(5'd4, 32'd44, "preload4");
   endtask

`ifdef RAM_CLEAR_EN
   // One cycle of CLEAR already elapsed in test_reset before waiting.
   task automatic wait_ready_after_release_minus1();
      int cnt;
      cnt = 1;
      while (ready !== 1'b1 && cnt < 200) begin
         step();
         cnt++;
      end
      checks++;
      if (cnt != 32) begin
         errors++;
         $display("FAIL ready_delay: got %0d cycles expected 32", cnt);
      end
   endtask
`endif

   task automatic test_write_forward();
      wen = 1'b1; waddr = 5'd3; wdata = 32'd17; raddr0 = 5'd3; raddr1 = 5'd3;
      step();
      wen = 1'b0;
      checks++;
      if (rdata0 !== 32'd17 || rdata1 !== 32'd17) begin
         errors++;
         $display("FAIL fwd_kernel: got %h/%h expected 17/17", rdata0, rdata1);
      end
      checks++;
      if (write_count !== 16'd1) begin
         errors++;
         $display("FAIL count_one: got %0d expected 1", write_count);
      end
      peek(5'd3, 32'd17, "commit3");
      raddr1 = 5'd4;
      step();
      checks++;
      if (rdata0 !== 32'd17 || rdata1 !== 32'd44) begin
         errors++;
         $display("FAIL plain_read: got %h/%h expected 17/44", rdata0, rdata1);
      end
   endtask

   task automatic test_collision();
      wen = 1'b1; waddr = 5'd7; wdata = 32'd5;
      debug_write_en = 1'b1; debug_write_addr = 5'd7; debug_write_data = 32'd9;
      raddr0 = 5'd7; raddr1 = 5'd7;
      step();
      checks++;
      if (rdata0 !== 32'd5 || rdata1 !== 32'd5) begin
         errors++;
         $display("FAIL collide_fwd: got %h/%h expected 5/5", rdata0, rdata1);
      end
      peek(5'd7, 32'd5, "collide_mem");
      checks++;
      if (write_count !== 16'd2) begin
         errors++;
         $display("FAIL collide_count: got %0d expected 2", write_count);
      end
      waddr = 5'd11; wdata = 32'd21; debug_write_addr = 5'd12; debug_write_data = 32'd33;
      raddr0 = 5'd12; raddr1 = 5'd11;
      step();
      idle_inputs();
      checks++;
      if (rdata0 !== 32'd33 || rdata1 !== 32'd21) begin
         errors++;
         $display("FAIL split_fwd: got %h/%h expected 33/21", rdata0, rdata1);
      end
      checks++;
      if (write_count !== 16'd3) begin
         errors++;
         $display("FAIL split_count: got %0d expected 3", write_count);
      end
      peek(5'd11, 32'd21, "split_k");
      peek(5'd12, 32'd33, "split_d");
   endtask

   task automatic test_read_ports();
      raddr0 = 5'd3; raddr1 = 5'd11;
      step();
      checks++;
      if (rdata0 !== 32'd17 || rdata1 !== 32'd21) begin
         errors++;
         $display("FAIL ports_a: got %h/%h expected 17/21", rdata0, rdata1);
      end
      raddr0 = 5'd12; raddr1 = 5'd7;
      step();
      checks++;
      if (rdata0 !== 32'd33 || rdata1 !== 32'd5) begin
         errors++;
         $display("FAIL ports_b: got %h/%h expected 33/5", rdata0, rdata1);
      end
   endtask

   task automatic test_midrun_reset();
      logic [31:0] exp;
      for (int i = 0; i < 4; i++) begin
         wen = 1'b1; waddr = 5'(16 + i); wdata = 32'(100 + i);
         step();
      end
      wen = 1'b0;
      checks++;
      if (write_count !== 16'd7) begin
         errors++;
         $display("FAIL pre_reset_count: got %0d expected 7", write_count);
      end
      rst = 1'b1; raddr0 = 5'd16; raddr1 = 5'd17;
      wen = 1'b1; waddr = 5'd16; wdata = 32'd999;
      step();
      wen = 1'b0;
      checks++;
      if (write_count !== 16'd0 || rdata0 !== 32'd0 || rdata1 !== 32'd0) begin
         errors++;
         $display("FAIL midrun_reset: count %0d rdata %h/%h expected 0/0/0", write_count, rdata0, rdata1);
      end
      rst = 1'b0;
      wait_ready_after_release();
      for (int i = 0; i < 4; i++) begin
`ifdef RAM_CLEAR_EN
         exp = 32'd0;
`else
         exp = 32'(100 + i);
`endif
         peek(5'(16 + i), exp, "keep_after_reset");
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 65540; i++) begin
         wen = 1'b1; waddr = 5'(i % 32); wdata = 32'(i);
         step();
         if (i == 65533) begin
            checks++;
            if (write_count !== 16'hFFFE) begin
               errors++;
               $display("FAIL sat_minus1: got %h expected fffe", write_count);
            end
         end
         if (i == 65534) begin
            checks++;
            if (write_count !== 16'hFFFF) begin
               errors++;
               $display("FAIL sat_reach: got %h expected ffff", write_count);
            end
         end
      end
      wen = 1'b0;
      checks++;
      if (write_count !== 16'hFFFF) begin
         errors++;
         $display("FAIL sat_hold: got %h expected ffff", write_count);
      end
      peek(5'd3, 32'd65539, "sat_lastdata");
   endtask

   initial begin
      test_reset();
      test_write_forward();
      test_collision();
      test_read_ports();
      test_midrun_reset();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
